// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer and its combinational ALU.
package alu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SUM_W   = DATA_W + 1;
    localparam int unsigned MODE_W  = 5;
    localparam int unsigned FLAGS_W = 4;

    // ALU mode encodings
    localparam logic [MODE_W-1:0] MODE_ADD = 5'd0;
    localparam logic [MODE_W-1:0] MODE_AND = 5'd1;
    localparam logic [MODE_W-1:0] MODE_OR  = 5'd2;
    localparam logic [MODE_W-1:0] MODE_XOR = 5'd3;
    localparam logic [MODE_W-1:0] MODE_SHL = 5'd4;

    // Bit positions inside flags = {N, V, Z, C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    typedef enum logic [2:0] {
        OP_ADC = 3'd0,
        OP_AND = 3'd1,
        OP_ORA = 3'd2,
        OP_EOR = 3'd3,
        OP_ASL = 3'd4,
        OP_CMP = 3'd5,
        OP_SBC = 3'd6,
        OP_LDA = 3'd7
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Operation request channel from the instruction decoder into the sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              op_valid;
    logic              op_ready;
    op_code_e          op_code;
    logic              op_dest;
    logic [DATA_W-1:0] operand;

    modport master (output op_valid, output op_code, output op_dest, output operand,
                    input  op_ready);
    modport slave  (input  op_valid, input  op_code, input  op_dest, input  operand,
                    output op_ready);
endinterface

// File: rtl/alu.sv
// Purely combinational 8-bit ALU: add-with-carry, logic ops, shift-left-by-one.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [MODE_W-1:0] mode,
    input  logic              cin,
    output logic [DATA_W-1:0] y_c,
    output logic              cout_c,
    output logic              ovf_c
);

    logic [SUM_W-1:0] sum_w;

    // Result, carry and signed overflow for the selected mode
    always_comb begin
        sum_w  = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
        y_c    = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        case (mode)
            MODE_ADD: begin
                y_c    = sum_w[DATA_W-1:0];
                cout_c = sum_w[DATA_W];
                ovf_c  = (a[DATA_W-1] == b[DATA_W-1]) && (y_c[DATA_W-1] != a[DATA_W-1]);
            end
            MODE_AND: y_c = a & b;
            MODE_OR:  y_c = a | b;
            MODE_XOR: y_c = a ^ b;
            MODE_SHL: begin
                y_c    = {a[DATA_W-2:0], 1'b0};
                cout_c = a[DATA_W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_flags.sv
// Next-state computation for the N/V/Z/C status flags.
module alu_flags
    import alu_pkg::*;
(
    input  op_code_e           op_code,
    input  logic               shift_bit,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_cout,
    input  logic               alu_ovf,
    input  logic [FLAGS_W-1:0] flags_cur,
    output logic [FLAGS_W-1:0] flags_nxt_c
);

    // N/Z follow every result; C and V only for the ops that define them
    always_comb begin
        flags_nxt_c         = flags_cur;
        flags_nxt_c[FLAG_N] = alu_out[DATA_W-1];
        flags_nxt_c[FLAG_Z] = (alu_out == '0);
        case (op_code)
            OP_ADC, OP_SBC: begin
                flags_nxt_c[FLAG_C] = alu_cout;
                flags_nxt_c[FLAG_V] = alu_ovf;
            end
            OP_CMP:  flags_nxt_c[FLAG_C] = alu_cout;
            OP_ASL:  flags_nxt_c[FLAG_C] = shift_bit;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one operation at a time to the ALU and owns the accumulator and status flags.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    alu_sequencer_if.slave      op_if,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [MODE_W-1:0]   alu_mode,
    output logic                alu_cin,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_cout,
    input  logic                alu_ovf,
    output logic                result_valid,
    output logic [DATA_W-1:0]   result,
    output logic [DATA_W-1:0]   acc,
    output logic [FLAGS_W-1:0]  flags
);

    state_e             state_q;
    state_e             state_d;
    logic               accept_c;

    op_code_e           code_q;
    logic               dest_q;

    logic [DATA_W-1:0]  drv_a_c;
    logic [DATA_W-1:0]  drv_b_c;
    logic [MODE_W-1:0]  drv_mode_c;
    logic               drv_cin_c;

    logic [DATA_W-1:0]  cap_out_q;
    logic [FLAGS_W-1:0] cap_flags_q;
    logic [FLAGS_W-1:0] flags_nxt_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; an op is taken only while idle
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_if.op_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ALU drive for the incoming op, loaded into registers on accept
    always_comb begin
        drv_a_c    = acc;
        drv_b_c    = op_if.operand;
        drv_mode_c = MODE_ADD;
        drv_cin_c  = 1'b0;
        case (op_if.op_code)
            OP_ADC: drv_cin_c = flags[FLAG_C];
            OP_SBC: begin
                drv_b_c   = ~op_if.operand;
                drv_cin_c = flags[FLAG_C];
            end
            OP_CMP: begin
                drv_b_c   = ~op_if.operand;
                drv_cin_c = 1'b1;
            end
            OP_AND: drv_mode_c = MODE_AND;
            OP_ORA: drv_mode_c = MODE_OR;
            OP_EOR: drv_mode_c = MODE_XOR;
            OP_LDA: begin
                drv_a_c    = '0;
                drv_mode_c = MODE_OR;
            end
            OP_ASL: begin
                drv_a_c    = op_if.op_dest ? op_if.operand : acc;
                drv_b_c    = '0;
                drv_mode_c = MODE_SHL;
            end
            default: ;
        endcase
    end

    // ALU drive registers: non-zero only during ISSUE
    always_ff @(posedge clk) begin
        if (reset || !accept_c) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
            alu_cin  <= 1'b0;
        end else begin
            alu_a    <= drv_a_c;
            alu_b    <= drv_b_c;
            alu_mode <= drv_mode_c;
            alu_cin  <= drv_cin_c;
        end
    end

    // Latched op fields used at writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= OP_ADC;
            dest_q <= 1'b0;
        end else if (accept_c) begin
            code_q <= op_if.op_code;
            dest_q <= op_if.op_dest;
        end
    end

    alu_flags u_flags (
        .op_code     (code_q),
        .shift_bit   (alu_a[DATA_W-1]),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .alu_ovf     (alu_ovf),
        .flags_cur   (flags),
        .flags_nxt_c (flags_nxt_c)
    );

    // Capture ALU outputs at the end of ISSUE, before the drive returns to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_out_q   <= '0;
            cap_flags_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            cap_out_q   <= alu_out;
            cap_flags_q <= flags_nxt_c;
        end
    end

    // Architectural writeback at the end of WRITE; a reset here aborts it
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid   <= 1'b0;
            result         <= '0;
            acc            <= '0;
            flags          <= '0;
            op_if.op_ready <= 1'b1;
        end else begin
            result_valid   <= (state_q == ST_WRITE);
            op_if.op_ready <= (state_d == ST_IDLE);
            if (state_q == ST_WRITE) begin
                result <= cap_out_q;
                flags  <= cap_flags_q;
                if (!dest_q && (code_q != OP_CMP)) acc <= cap_out_q;
            end
        end
    end

endmodule
